// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data memory.
//   state_t  : access FSM states
//   clog2    : ceil(log2(v)), for index / offset widths
//   bytes_of : byte lanes in a data word
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Byte lanes for the default 32-bit word.
  localparam int BYTES = 4;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction

  function automatic int bytes_of(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port RAM with per-byte write enables and a registered read port.
//   clk   : rising-edge clock
//   en    : access this cycle
//   we    : 1 = write enabled lanes, 0 = read word into rdata
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   idx   : word index
//   wdata : write data
//   rdata : read data, updated only on a read access
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int NB    = bytes_of(DATA_W),
  localparam int IDX_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // One narrow memory per byte lane so each strobe maps to its own write port.
  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic [7:0] mem [DEPTH] = '{default: 8'h00};
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (be[g]) mem[idx] <= wdata[g*8 +: 8];
        end else begin
          q <= mem[idx];
        end
      end
    end

    assign rdata[g*8 +: 8] = q;
  end

endmodule

// File: rtl/dmem_wait.sv
// Data memory with valid/ready request and response ports, byte strobes and
// a fixed number of wait states between accept and response.
//   clk, rst_n   : clock, synchronous active-low reset
//   req_valid    : request present          req_ready : idle, can accept
//   req_write    : 1 = write, 0 = read      req_addr  : byte address
//   req_wdata    : write data               req_be    : byte enables
//   resp_valid   : response present         resp_ready: consumer takes it
//   resp_rdata   : read data (0 for writes/errors)
//   resp_err     : misaligned or out-of-range access
module dmem_wait
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  parameter int BASE    = 0,
  localparam int NB     = bytes_of(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int BLOG  = clog2(NB);
  localparam int IDX_W = clog2(DEPTH);

  state_t              state, state_nx;
  logic [3:0]          cnt;
  logic                rd_ok;   // response carries array data
  logic                err_q;
  logic                accept;
  logic                bad;
  logic [ADDR_W-1:0]   word_off;
  logic [DATA_W-1:0]   arr_rdata;

  assign accept   = req_valid & req_ready;
  assign word_off = (req_addr - ADDR_W'(BASE)) >> BLOG;
  assign bad      = ((req_addr & ADDR_W'(NB - 1)) != '0)
                  | (req_addr < ADDR_W'(BASE))
                  | (word_off >= ADDR_W'(DEPTH));

  // Array is touched only on a clean accept; held off during reset so a
  // request presented alongside reset cannot commit.
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (accept & ~bad & rst_n),
    .we    (req_write),
    .be    (req_be),
    .idx   (word_off[IDX_W-1:0]),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // cnt is 1 after the accept edge; RESP is entered on the edge where it
  // already equals LATENCY-1, so resp_valid rises LATENCY edges after
  // accept counting the accept edge itself.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 4'(LATENCY - 1)) state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = rd_ok ? arr_rdata : '0;
    resp_err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)               cnt <= '0;
    else if (accept)          cnt <= 4'd1;
    else if (state == WAIT)   cnt <= cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      rd_ok <= ~bad & ~req_write;
      err_q <= bad;
    end else if (resp_valid & resp_ready) begin
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_wait.sv
module tb_dmem_wait;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_write, resp_ready, sel;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b;
  logic [31:0] rd_a, rd_b;
  logic        rdy, vld, err;
  logic [31:0] rd;

  // Two instances share stimulus; sel picks which one sees valid/ready.
  dmem_wait #(.LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .resp_valid(vld_a), .resp_ready(resp_ready & ~sel),
    .resp_rdata(rd_a), .resp_err(err_a));

  dmem_wait #(.LATENCY(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy_b),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .resp_valid(vld_b), .resp_ready(resp_ready & sel),
    .resp_rdata(rd_b), .resp_err(err_b));

  assign rdy = sel ? rdy_b : rdy_a;
  assign vld = sel ? vld_b : vld_a;
  assign err = sel ? err_b : err_a;
  assign rd  = sel ? rd_b  : rd_a;

  typedef struct { logic [31:0] d; logic e; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one request, check latency/busy, optionally stall the response,
  // then compare the response against the scoreboard.
  task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e,
                      input int hold, input int lat);
    int n;
    int edges;
    logic [31:0] d0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wd; req_be = be;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    chk("ready_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    sb.push_back('{exp_d, exp_e});
    #1 req_valid = 1'b0;
    edges = 1;
    while (!vld && edges < 40) begin
      chk("busy_ready", 32'(rdy), 32'd0);
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", 32'(edges), 32'(lat));
    d0 = rd;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(vld), 32'd1);
      chk("hold_rdata", rd, d0);
      chk("hold_ready", 32'(rdy), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    d0 = rd;
    n  = 32'(err);
    @(posedge clk);
    e = sb.pop_front();
    chk("resp_rdata", d0, e.d);
    chk("resp_err", 32'(n), 32'(e.e));
    #1;
    chk("post_valid", 32'(vld), 32'd0);
    chk("post_ready", 32'(rdy), 32'd1);
    chk("post_rdata", rd, 32'd0);
    resp_ready = 1'b0;
  endtask

  // Accept a request on dut_b, then reset it one edge into the wait.
  task automatic reset_in_wait(input logic w, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wd; req_be = 4'hf;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("wait_ready", 32'(rdy), 32'd0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("dropped_valid", 32'(vld), 32'd0);
      chk("reset_ready", 32'(rdy), 32'd1);
    end
  endtask

  initial begin
    sel = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_a", 32'(rdy_a), 32'd1);
    chk("rst_valid_a", 32'(vld_a), 32'd0);
    chk("rst_rdata_a", rd_a, 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_ready_b", 32'(rdy_b), 32'd1);
    chk("rst_valid_b", 32'(vld_b), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // latency 1 writes / reads
    xfer(1, 32'd16, 32'h12345678, 4'hf, 32'h0, 0, 0, 1);
    xfer(1, 32'd24, 32'h89ABCDEF, 4'hf, 32'h0, 0, 0, 1);
    xfer(0, 32'd16, 32'h0, 4'h0, 32'h12345678, 0, 0, 1);
    xfer(0, 32'd20, 32'h0, 4'h0, 32'h00000000, 0, 0, 1);
    xfer(0, 32'd24, 32'h0, 4'hf, 32'h89ABCDEF, 0, 0, 1);

    // byte strobes and empty strobe
    xfer(1, 32'd32, 32'h11223344, 4'hf, 32'h0, 0, 0, 1);
    xfer(1, 32'd32, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0, 1);
    xfer(0, 32'd32, 32'h0, 4'h0, 32'h11BB33DD, 0, 0, 1);
    xfer(1, 32'd32, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 0, 1);
    xfer(0, 32'd32, 32'h0, 4'h0, 32'h11BB33DD, 0, 0, 1);

    // errors: misaligned, out of range, last legal word untouched
    xfer(0, 32'd18, 32'h0, 4'hf, 32'h0, 1, 0, 1);
    xfer(1, 32'd4096, 32'hDEADBEEF, 4'hf, 32'h0, 1, 0, 1);
    xfer(0, 32'd4096, 32'h0, 4'hf, 32'h0, 1, 0, 1);
    xfer(0, 32'd4092, 32'h0, 4'hf, 32'h0, 0, 0, 1);

    // stalled response, then back-to-back request
    xfer(0, 32'd24, 32'h0, 4'hf, 32'h89ABCDEF, 0, 5, 1);
    xfer(0, 32'd16, 32'h0, 4'hf, 32'h12345678, 0, 0, 1);

    // latency 4 instance
    @(negedge clk) sel = 1'b1;
    xfer(1, 32'd16, 32'h12345678, 4'hf, 32'h0, 0, 0, 4);
    xfer(0, 32'd16, 32'h0, 4'hf, 32'h12345678, 0, 0, 4);
    xfer(0, 32'd18, 32'h0, 4'hf, 32'h0, 1, 3, 4);

    // reset during wait: read dropped; write already committed survives
    reset_in_wait(0, 32'd16, 32'h0);
    reset_in_wait(1, 32'd40, 32'hCAFEF00D);
    xfer(0, 32'd40, 32'h0, 4'hf, 32'hCAFEF00D, 0, 0, 4);
    xfer(0, 32'd16, 32'h0, 4'hf, 32'h12345678, 0, 0, 4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
